// File: rtl/alut_pkg.sv
// Shared definitions for the address lookup table memory and its two-client arbiter.
// Covers the table geometry, the entry field positions and the arbiter state encoding.
package alut_pkg;

  localparam int ALUT_ADDR_W = 8;
  localparam int ALUT_DATA_W = 83;
  localparam int ALUT_DEPTH  = 256;

  localparam int ENT_VALID_BIT = 82;
  localparam int ENT_TIME_MSB  = 81;
  localparam int ENT_TIME_LSB  = 50;
  localparam int ENT_PORT_MSB  = 49;
  localparam int ENT_PORT_LSB  = 48;
  localparam int ENT_MAC_MSB   = 47;
  localparam int ENT_MAC_LSB   = 0;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_GNT_ADD = 2'd2,
    ST_GNT_AGE = 2'd3
  } arb_state_t;

  function automatic logic [ALUT_DATA_W-1:0] pack_entry(input logic        valid,
                                                        input logic [31:0] last_time,
                                                        input logic [1:0]  port,
                                                        input logic [47:0] mac);
    return {valid, last_time, port, mac};
  endfunction

endpackage

// File: rtl/alut_mem_array.sv
// Single-port lookup table storage: synchronous write, synchronous write-first read.
// Contents are never reset; the arbiter clears them with its init sweep.
module alut_mem_array
  import alut_pkg::*;
(
  input  logic                   pclk,
  input  logic [ALUT_ADDR_W-1:0] addr,
  input  logic                   wr_en,
  input  logic [ALUT_DATA_W-1:0] wdata,
  output logic [ALUT_DATA_W-1:0] rdata
);

  logic [ALUT_DATA_W-1:0] mem [ALUT_DEPTH];

  always_ff @(posedge pclk) begin
    if (wr_en) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/alut_mem_arb.sv
// Arbiter between the address checker and the age checker for the shared lookup table.
// Clears the table after reset, then grants whole-transaction locks with the address checker preferred.
module alut_mem_arb
  import alut_pkg::*;
(
  input  logic                   pclk,
  input  logic                   p_reset,
  input  logic                   age_check_active,
  input  logic [ALUT_ADDR_W-1:0] mem_addr_age,
  input  logic                   mem_write_age,
  input  logic [ALUT_DATA_W-1:0] mem_write_data_age,
  input  logic                   add_check_active,
  input  logic [ALUT_ADDR_W-1:0] mem_addr_add,
  input  logic                   mem_write_add,
  input  logic [ALUT_DATA_W-1:0] mem_write_data_add,
  output logic [ALUT_DATA_W-1:0] mem_read_data_age,
  output logic [ALUT_DATA_W-1:0] mem_read_data_add,
  output logic                   gnt_age,
  output logic                   gnt_add,
  output logic                   mem_init_done
);

  arb_state_t             state;
  logic [ALUT_ADDR_W-1:0] init_ptr;
  logic [ALUT_ADDR_W-1:0] mux_addr;
  logic                   mux_wr;
  logic [ALUT_DATA_W-1:0] mux_wdata;
  logic [ALUT_DATA_W-1:0] mem_rdata;
  logic                   sel_add_p1, sel_age_p1;
  logic [ALUT_DATA_W-1:0] hold_add_p1, hold_age_p1;

  // Grants and init_done are registered alongside the state so they never glitch.
  always_ff @(posedge pclk) begin
    if (p_reset) begin
      state         <= ST_INIT;
      init_ptr      <= '0;
      mem_init_done <= 1'b0;
      gnt_add       <= 1'b0;
      gnt_age       <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == '1) begin
            state         <= ST_IDLE;
            mem_init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (add_check_active) begin
            state   <= ST_GNT_ADD;
            gnt_add <= 1'b1;
          end else if (age_check_active) begin
            state   <= ST_GNT_AGE;
            gnt_age <= 1'b1;
          end
        end
        ST_GNT_ADD: begin
          if (!add_check_active) begin
            gnt_add <= 1'b0;
            if (age_check_active) begin
              state   <= ST_GNT_AGE;
              gnt_age <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_GNT_AGE: begin
          if (!age_check_active) begin
            gnt_age <= 1'b0;
            if (add_check_active) begin
              state   <= ST_GNT_ADD;
              gnt_add <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Access mux: init sweep, else the granted client; writes are suppressed while in reset.
  always_comb begin
    mux_addr  = mem_addr_add;
    mux_wr    = 1'b0;
    mux_wdata = mem_write_data_add;
    unique case (state)
      ST_INIT: begin
        mux_addr  = init_ptr;
        mux_wr    = 1'b1;
        mux_wdata = '0;
      end
      ST_GNT_ADD: mux_wr = mem_write_add;
      ST_GNT_AGE: begin
        mux_addr  = mem_addr_age;
        mux_wr    = mem_write_age;
        mux_wdata = mem_write_data_age;
      end
      default: ;
    endcase
    if (p_reset) mux_wr = 1'b0;
  end

  alut_mem_array u_mem (
    .pclk  (pclk),
    .addr  (mux_addr),
    .wr_en (mux_wr),
    .wdata (mux_wdata),
    .rdata (mem_rdata)
  );

  // Stage p1: remember which client owns the fresh read word; each output holds its last word otherwise.
  always_ff @(posedge pclk) begin
    if (p_reset) begin
      sel_add_p1  <= 1'b0;
      sel_age_p1  <= 1'b0;
      hold_add_p1 <= '0;
      hold_age_p1 <= '0;
    end else begin
      sel_add_p1 <= gnt_add;
      sel_age_p1 <= gnt_age;
      if (sel_add_p1) hold_add_p1 <= mem_rdata;
      if (sel_age_p1) hold_age_p1 <= mem_rdata;
    end
  end

  assign mem_read_data_add = sel_add_p1 ? mem_rdata : hold_add_p1;
  assign mem_read_data_age = sel_age_p1 ? mem_rdata : hold_age_p1;

endmodule

// File: tb/tb_alut_mem_arb.sv
// Bench for alut_mem_arb: directed scenarios plus randomized traffic against a behavioural model.
module tb_alut_mem_arb;
  import alut_pkg::*;

  logic        pclk = 1'b0;
  logic        p_reset;
  logic        age_check_active, add_check_active;
  logic [7:0]  mem_addr_age, mem_addr_add;
  logic        mem_write_age, mem_write_add;
  logic [82:0] mem_write_data_age, mem_write_data_add;
  logic [82:0] mem_read_data_age, mem_read_data_add;
  logic        gnt_age, gnt_add, mem_init_done;

  always #5 pclk = ~pclk;

  alut_mem_arb dut (
    .pclk               (pclk),
    .p_reset            (p_reset),
    .age_check_active   (age_check_active),
    .mem_addr_age       (mem_addr_age),
    .mem_write_age      (mem_write_age),
    .mem_write_data_age (mem_write_data_age),
    .add_check_active   (add_check_active),
    .mem_addr_add       (mem_addr_add),
    .mem_write_add      (mem_write_add),
    .mem_write_data_add (mem_write_data_add),
    .mem_read_data_age  (mem_read_data_age),
    .mem_read_data_add  (mem_read_data_add),
    .gnt_age            (gnt_age),
    .gnt_add            (gnt_add),
    .mem_init_done      (mem_init_done)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [82:0] got, input logic [82:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural model: table contents, who holds the table, and each client's last read word.
  logic [82:0] m_mem [256];
  int          m_init_cnt;
  bit          m_done;
  int          m_owner;  // 0 nobody, 1 address checker, 2 age checker
  logic [82:0] m_rd_add, m_rd_age;

  task automatic model_step();
    if (p_reset) begin
      m_init_cnt = 0;
      m_done     = 0;
      m_owner    = 0;
      m_rd_add   = '0;
      m_rd_age   = '0;
    end else if (!m_done) begin
      m_mem[m_init_cnt] = '0;
      m_init_cnt++;
      if (m_init_cnt == 256) m_done = 1;
    end else begin
      if (m_owner == 1) begin
        if (mem_write_add) m_mem[mem_addr_add] = mem_write_data_add;
        m_rd_add = m_mem[mem_addr_add];
      end else if (m_owner == 2) begin
        if (mem_write_age) m_mem[mem_addr_age] = mem_write_data_age;
        m_rd_age = m_mem[mem_addr_age];
      end
      if (m_owner == 1 && add_check_active) m_owner = 1;
      else if (m_owner == 2 && age_check_active) m_owner = 2;
      else if (m_owner == 2) m_owner = add_check_active ? 1 : 0;
      else if (add_check_active) m_owner = 1;
      else if (age_check_active) m_owner = 2;
      else m_owner = 0;
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    model_step();
    @(negedge pclk);
    check_eq("gnt_add", gnt_add, (m_owner == 1));
    check_eq("gnt_age", gnt_age, (m_owner == 2));
    check_eq("init_done", mem_init_done, m_done);
    check_eq("rd_add", mem_read_data_add, m_rd_add);
    check_eq("rd_age", mem_read_data_age, m_rd_age);
  endtask

  task automatic drive_idle();
    add_check_active   = 1'b0;
    age_check_active   = 1'b0;
    mem_write_add      = 1'b0;
    mem_write_age      = 1'b0;
    mem_addr_add       = '0;
    mem_addr_age       = '0;
    mem_write_data_add = '0;
    mem_write_data_age = '0;
  endtask

  function automatic logic [82:0] rnd83();
    return 83'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [7:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    return (r == 9) ? 8'hff : 8'(r);
  endfunction

  logic [82:0] v27, v29, saved_add, nz;

  initial begin
    drive_idle();
    p_reset = 1'b1;
    tick();
    check_eq("rst_gnt_add", gnt_add, 0);
    check_eq("rst_done", mem_init_done, 0);
    p_reset = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      add_check_active = 1'b1;
      age_check_active = 1'b1;
      tick();
      if (i == 255) check_eq("init_not_yet", mem_init_done, 0);
    end
    check_eq("init_done_256", mem_init_done, 1);
    check_eq("init_no_grant", gnt_add, 0);

    // Readback of a cleared table through the address checker.
    drive_idle();
    add_check_active = 1'b1;
    for (int i = 0; i < 12; i++) begin
      mem_addr_add = rnd_addr();
      tick();
    end
    check_eq("cleared_read", mem_read_data_add, '0);

    // Write-then-read at 8'h10.
    v27 = pack_entry(1'b1, 32'h0000_0005, 2'b01, 48'h0011_2233_4455);
    mem_addr_add = 8'h10; mem_write_add = 1'b1; mem_write_data_add = v27;
    tick();
    mem_write_add = 1'b0;
    tick();
    check_eq("read_10", mem_read_data_add, v27);
    drive_idle();
    tick();

    // Simultaneous requests: address checker wins, age follows without an idle bubble.
    add_check_active = 1'b1; age_check_active = 1'b1;
    tick();
    check_eq("both_req_add", gnt_add, 1);
    check_eq("both_req_age", gnt_age, 0);
    tick();
    add_check_active = 1'b0;
    tick();
    check_eq("handover_age", gnt_age, 1);

    // Age lock holds off the address checker; its write to 8'h20 is dropped.
    v29 = rnd83();
    add_check_active = 1'b1; mem_addr_add = 8'h20; mem_write_add = 1'b1; mem_write_data_add = v29;
    mem_addr_age = 8'h20;
    for (int i = 0; i < 3; i++) tick();
    check_eq("lock_no_add", gnt_add, 0);
    check_eq("entry20_kept", mem_read_data_age, '0);
    mem_write_add = 1'b0;
    tick();
    age_check_active = 1'b0;
    tick();
    check_eq("lock_release_add", gnt_add, 1);
    tick();
    check_eq("entry20_add_view", mem_read_data_add, '0);

    // Age checker writes 0xff then clears it; address checker output untouched.
    add_check_active = 1'b0; age_check_active = 1'b1;
    tick();
    tick();
    saved_add = mem_read_data_add;
    nz = rnd83() | 83'd1;
    mem_addr_age = 8'hff; mem_write_age = 1'b1; mem_write_data_age = nz;
    tick();
    check_eq("ff_write_nz", mem_read_data_age, nz);
    mem_write_data_age = '0;
    tick();
    check_eq("ff_write_zero", mem_read_data_age, '0);
    check_eq("ff_add_unchanged", mem_read_data_add, saved_add);
    drive_idle();
    tick();

    // Reset in the middle of an address-checker grant.
    add_check_active = 1'b1;
    tick();
    tick();
    p_reset = 1'b1;
    tick();
    check_eq("midrst_gnt", gnt_add, 0);
    check_eq("midrst_rd", mem_read_data_add, '0);
    p_reset = 1'b0;
    for (int i = 1; i <= 256; i++) tick();
    check_eq("reinit_done", mem_init_done, 1);

    // Randomized traffic with occasional resets.
    drive_idle();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) add_check_active = ~add_check_active;
      if ($urandom_range(0, 3) == 0) age_check_active = ~age_check_active;
      mem_addr_add       = rnd_addr();
      mem_addr_age       = rnd_addr();
      mem_write_add      = ($urandom_range(0, 2) == 0);
      mem_write_age      = ($urandom_range(0, 2) == 0);
      mem_write_data_add = rnd83();
      mem_write_data_age = rnd83();
      p_reset            = ($urandom_range(0, 999) == 0);
      tick();
    end
    p_reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/alut_mem_arb.md
ALUT_MEM_ARB -- requirements
Module: alut_mem_arb

Interface
REQ-001 SHALL have ports: pclk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: p_reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: age_check_active in 1 age checker access request/lock; mem_addr_age in 8; mem_write_age in 1 (write=high); mem_write_data_age in 83.
REQ-004 SHALL have ports: add_check_active in 1 address checker request/lock; mem_addr_add in 8; mem_write_add in 1; mem_write_data_add in 83.
REQ-005 SHALL have ports: mem_read_data_age out 83; mem_read_data_add out 83; gnt_age out 1; gnt_add out 1; mem_init_done out 1.
REQ-006 Entry format SHALL be: [82] valid, [81:50] last_accessed time, [49:48] port, [47:0] MAC address.

Function
REQ-007 FSM states SHALL be INIT, IDLE, GNT_ADD, GNT_AGE.
REQ-008 INIT SHALL write 83'd0 to addresses 0..255 in ascending order, one per cycle, 256 cycles, then go to IDLE and set mem_init_done (held until reset).
REQ-009 In INIT both grants SHALL be low and all port requests ignored.
REQ-010 IDLE: add_check_active high -> GNT_ADD; else age_check_active high -> GNT_AGE; else stay; simultaneous requests -> address checker wins.
REQ-011 GNT_ADD SHALL hold while add_check_active high; on its drop -> GNT_AGE if age_check_active high, else IDLE (no idle bubble).
REQ-012 GNT_AGE SHALL hold while age_check_active high (lock, no preemption by address checker); on drop -> GNT_ADD if add_check_active high, else IDLE.
REQ-013 gnt_add/gnt_age SHALL be registered decodes of GNT_ADD/GNT_AGE, never both high.
REQ-014 Memory access SHALL occur only from the granted port, using that port's addr/write/wdata in the same cycle the grant is high.
REQ-015 Write: entry updated at the clock edge ending the granted cycle.
REQ-016 Read latency SHALL be one cycle: data for address sampled at edge N appears on the granted port's read-data output after edge N.
REQ-017 In a write cycle the granted port's read data SHALL return the written data (write-first).
REQ-018 Each read-data output SHALL update only on cycles its port is granted and SHALL hold its last value otherwise.
REQ-019 Non-granted port's write requests SHALL be dropped (no queuing); no memory change.
REQ-020 Address 8'hff SHALL be a normal entry; no wrap logic beyond 8-bit address.

Reset
REQ-021 p_reset high SHALL force state INIT, init pointer 0, mem_init_done 0, gnt_age 0, gnt_add 0, both read-data outputs 83'd0.
REQ-022 Reset asserted mid-INIT or mid-grant SHALL abort the operation and restart the full 256-entry clear on release.
REQ-023 Memory contents are not reset directly; cleared only by INIT sweep.

Structure
REQ-024 Shared package alut_pkg SHALL hold ALUT_ADDR_W=8, ALUT_DATA_W=83, ALUT_DEPTH=256, entry field bit positions (valid, time, port, MAC), and arbiter state encoding.
REQ-025 Storage SHALL be sub-module alut_mem_array: 256x83 single-port, synchronous write, synchronous write-first read; arbiter supplies one muxed addr/write/wdata.

Verification
REQ-026 Reset 1 cycle then release -> mem_init_done rises exactly 256 cycles after release; every readback 83'd0.
REQ-027 add writes addr 8'h10 data {1,32'h0000_0005,2'b01,48'h0011_2233_4455}; next cycle reads 8'h10 -> mem_read_data_add equals that value one cycle later.
REQ-028 add_check_active and age_check_active rise same cycle in IDLE -> gnt_add high, gnt_age low; add drops -> gnt_age high next cycle, no IDLE cycle.
REQ-029 GNT_AGE held, add_check_active rises with write to 8'h20 -> entry 8'h20 unchanged, gnt_add stays low until age_check_active drops.
REQ-030 age writes 83'd0 to 8'hff with write-first -> mem_read_data_age 83'd0 next cycle; mem_read_data_add unchanged.
REQ-031 p_reset pulsed during GNT_ADD at init pointer irrelevant -> grants drop, read data 0, full INIT repeats (256 cycles).
